// File: rtl/ex_stage_pkg.sv
// Shared opcodes, result-select codes, exception bit positions and divider
// state encoding for the execute stage.
package ex_stage_pkg;

   localparam int DIV_CYCLES = 32;

   localparam logic [7:0] EXE_NOP_OP   = 8'b00000000;
   localparam logic [7:0] EXE_AND_OP   = 8'b00100100;
   localparam logic [7:0] EXE_OR_OP    = 8'b00100101;
   localparam logic [7:0] EXE_XOR_OP   = 8'b00100110;
   localparam logic [7:0] EXE_NOR_OP   = 8'b00100111;
   localparam logic [7:0] EXE_SLL_OP   = 8'b01111100;
   localparam logic [7:0] EXE_SRL_OP   = 8'b00000010;
   localparam logic [7:0] EXE_SRA_OP   = 8'b00000011;
   localparam logic [7:0] EXE_MOVZ_OP  = 8'b00001010;
   localparam logic [7:0] EXE_MOVN_OP  = 8'b00001011;
   localparam logic [7:0] EXE_MFHI_OP  = 8'b00010000;
   localparam logic [7:0] EXE_MTHI_OP  = 8'b00010001;
   localparam logic [7:0] EXE_MFLO_OP  = 8'b00010010;
   localparam logic [7:0] EXE_MTLO_OP  = 8'b00010011;
   localparam logic [7:0] EXE_SLT_OP   = 8'b00101010;
   localparam logic [7:0] EXE_SLTU_OP  = 8'b00101011;
   localparam logic [7:0] EXE_ADD_OP   = 8'b00100000;
   localparam logic [7:0] EXE_ADDU_OP  = 8'b00100001;
   localparam logic [7:0] EXE_SUB_OP   = 8'b00100010;
   localparam logic [7:0] EXE_SUBU_OP  = 8'b00100011;
   localparam logic [7:0] EXE_ADDI_OP  = 8'b01010101;
   localparam logic [7:0] EXE_ADDIU_OP = 8'b01010110;
   localparam logic [7:0] EXE_MULT_OP  = 8'b00011000;
   localparam logic [7:0] EXE_MULTU_OP = 8'b00011001;
   localparam logic [7:0] EXE_MUL_OP   = 8'b10101001;
   localparam logic [7:0] EXE_DIV_OP   = 8'b00011010;
   localparam logic [7:0] EXE_DIVU_OP  = 8'b00011011;
   localparam logic [7:0] EXE_JAL_OP   = 8'b01010000;
   localparam logic [7:0] EXE_LW_OP    = 8'b11100011;

   localparam logic [2:0] EXE_RES_NOP         = 3'b000;
   localparam logic [2:0] EXE_RES_LOGIC       = 3'b001;
   localparam logic [2:0] EXE_RES_SHIFT       = 3'b010;
   localparam logic [2:0] EXE_RES_MOVE        = 3'b011;
   localparam logic [2:0] EXE_RES_ARITH       = 3'b100;
   localparam logic [2:0] EXE_RES_MUL         = 3'b101;
   localparam logic [2:0] EXE_RES_JUMP_BRANCH = 3'b110;
   localparam logic [2:0] EXE_RES_LOAD_STORE  = 3'b111;

   localparam int EXC_RI_BIT = 9;
   localparam int EXC_OV_BIT = 12;

   typedef enum logic [1:0] {
      DIV_IDLE    = 2'b00,
      DIV_BY_ZERO = 2'b01,
      DIV_ON      = 2'b10,
      DIV_END     = 2'b11
   } div_state_e;

   function automatic logic [31:0] neg32(input logic [31:0] v);
      return ~v + 32'd1;
   endfunction

endpackage

// File: rtl/ex_stage_div_unit.sv
// Iterative restoring divider, one quotient bit per cycle; signed operands are
// divided as magnitudes and the signs are restored when the result is latched.
//   state       | meaning
//   DIV_IDLE    | waiting for start
//   DIV_BY_ZERO | divisor was zero, result forced to 0
//   DIV_ON      | iterating, cnt_q counts quotient bits done
//   DIV_END     | result valid, held until div_release
module div_unit
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        signed_div,
   input  logic [31:0] opdata1,
   input  logic [31:0] opdata2,
   input  logic        start,
   input  logic        annul,
   input  logic        div_release,
   output logic [63:0] result,
   output logic        ready
);

   div_state_e  state_q, state_d;
   logic [5:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
   logic        neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
   logic [63:0] result_q, result_d;
   logic [32:0] trial;
   logic [31:0] rem_nxt, quo_nxt;

   // quo_q starts as the dividend and shifts out into the partial remainder
   always_comb begin
      trial = {rem_q, quo_q[31]} - {1'b0, dvs_q};
      if (!trial[32]) begin
         rem_nxt = trial[31:0];
         quo_nxt = {quo_q[30:0], 1'b1};
      end else begin
         rem_nxt = {rem_q[30:0], quo_q[31]};
         quo_nxt = {quo_q[30:0], 1'b0};
      end
   end

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quo_d     = quo_q;
      dvs_d     = dvs_q;
      neg_quo_d = neg_quo_q;
      neg_rem_d = neg_rem_q;
      result_d  = result_q;
      if (annul) begin
         state_d = DIV_IDLE;
         cnt_d   = '0;
      end else begin
         case (state_q)
            DIV_IDLE: begin
               if (start) begin
                  if (opdata2 == 32'd0) begin
                     state_d = DIV_BY_ZERO;
                  end else begin
                     state_d   = DIV_ON;
                     cnt_d     = '0;
                     rem_d     = '0;
                     quo_d     = (signed_div && opdata1[31]) ? neg32(opdata1) : opdata1;
                     dvs_d     = (signed_div && opdata2[31]) ? neg32(opdata2) : opdata2;
                     neg_quo_d = signed_div && (opdata1[31] ^ opdata2[31]);
                     neg_rem_d = signed_div && opdata1[31];
                  end
               end
            end
            DIV_BY_ZERO: begin
               state_d  = DIV_END;
               result_d = '0;
            end
            DIV_ON: begin
               rem_d = rem_nxt;
               quo_d = quo_nxt;
               cnt_d = cnt_q + 6'd1;
               if (cnt_q == 6'(DIV_CYCLES - 1)) begin
                  state_d  = DIV_END;
                  cnt_d    = '0;
                  result_d = {neg_rem_q ? neg32(rem_nxt) : rem_nxt,
                              neg_quo_q ? neg32(quo_nxt) : quo_nxt};
               end
            end
            DIV_END: begin
               if (div_release) state_d = DIV_IDLE;
            end
            default: state_d = DIV_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= DIV_IDLE;
         cnt_q     <= '0;
         rem_q     <= '0;
         quo_q     <= '0;
         dvs_q     <= '0;
         neg_quo_q <= 1'b0;
         neg_rem_q <= 1'b0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quo_q     <= quo_d;
         dvs_q     <= dvs_d;
         neg_quo_q <= neg_quo_d;
         neg_rem_q <= neg_rem_d;
         result_q  <= result_d;
      end
   end

   assign result = result_q;
   assign ready  = (state_q == DIV_END);

endmodule

// File: rtl/ex_stage.sv
// MIPS32 execute stage: ALU/shift/move/multiply results, overflow trap, HI/LO
// forwarding, effective address. Divider present only when EX_DIV_EN is defined.
module ex_stage
   import ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        stall_i,
   input  logic [7:0]  aluop_i,
   input  logic [2:0]  alusel_i,
   input  logic [31:0] reg1_i,
   input  logic [31:0] reg2_i,
   input  logic [4:0]  wd_i,
   input  logic        wreg_i,
   input  logic [31:0] link_address_i,
   input  logic [31:0] inst_i,
   input  logic [31:0] current_inst_address_i,
   input  logic [31:0] excepttype_i,
   input  logic        is_in_delayslot_i,
   input  logic [31:0] hi_i,
   input  logic [31:0] lo_i,
   input  logic        mem_whilo_i,
   input  logic [31:0] mem_hi_i,
   input  logic [31:0] mem_lo_i,
   input  logic        wb_whilo_i,
   input  logic [31:0] wb_hi_i,
   input  logic [31:0] wb_lo_i,
   output logic [4:0]  wd_o,
   output logic        wreg_o,
   output logic [31:0] wdata_o,
   output logic        whilo_o,
   output logic [31:0] hi_o,
   output logic [31:0] lo_o,
   output logic [31:0] mem_addr_o,
   output logic [31:0] reg2_o,
   output logic [7:0]  aluop_o,
   output logic [31:0] excepttype_o,
   output logic [31:0] current_inst_address_o,
   output logic        is_in_delayslot_o,
   output logic        stallreq_o
);

   logic [31:0] hi_cur, lo_cur, sum, diff;
   logic [63:0] prod_s, prod_u, div_result;
   logic        div_op, div_ready, div_rsvd, ov;
   logic        unused_ok;

   assign hi_cur = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
   assign lo_cur = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);

   assign sum    = reg1_i + reg2_i;
   assign diff   = reg1_i - reg2_i;
   assign prod_s = {{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i};
   assign prod_u = {32'd0, reg1_i} * {32'd0, reg2_i};

   assign div_op = (aluop_i == EXE_DIV_OP) || (aluop_i == EXE_DIVU_OP);

   // Only the trapping forms can raise overflow
   always_comb begin
      ov = 1'b0;
      if (aluop_i == EXE_ADD_OP || aluop_i == EXE_ADDI_OP)
         ov = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
      else if (aluop_i == EXE_SUB_OP)
         ov = (reg1_i[31] != reg2_i[31]) && (diff[31] != reg1_i[31]);
   end

`ifdef EX_DIV_EN
   div_unit u_div (
      .clk         (clk),
      .rst         (rst),
      .signed_div  (aluop_i == EXE_DIV_OP),
      .opdata1     (reg1_i),
      .opdata2     (reg2_i),
      .start       (div_op),
      .annul       (flush),
      .div_release (~stall_i),
      .result      (div_result),
      .ready       (div_ready)
   );
   assign div_rsvd   = 1'b0;
   assign stallreq_o = div_op && !div_ready && !flush;
   assign unused_ok  = &{1'b0, inst_i[31:16]};
`else
   assign div_result = '0;
   assign div_ready  = 1'b0;
   assign div_rsvd   = div_op;
   assign stallreq_o = 1'b0;
   assign unused_ok  = &{1'b0, inst_i[31:16], clk, rst, flush, stall_i};
`endif

   always_comb begin
      wdata_o = '0;
      case (alusel_i)
         EXE_RES_LOGIC: begin
            case (aluop_i)
               EXE_AND_OP: wdata_o = reg1_i & reg2_i;
               EXE_OR_OP:  wdata_o = reg1_i | reg2_i;
               EXE_XOR_OP: wdata_o = reg1_i ^ reg2_i;
               EXE_NOR_OP: wdata_o = ~(reg1_i | reg2_i);
               default:    wdata_o = '0;
            endcase
         end
         EXE_RES_SHIFT: begin
            case (aluop_i)
               EXE_SLL_OP: wdata_o = reg2_i << reg1_i[4:0];
               EXE_SRL_OP: wdata_o = reg2_i >> reg1_i[4:0];
               EXE_SRA_OP: wdata_o = $signed(reg2_i) >>> reg1_i[4:0];
               default:    wdata_o = '0;
            endcase
         end
         EXE_RES_MOVE: begin
            case (aluop_i)
               EXE_MFHI_OP: wdata_o = hi_cur;
               EXE_MFLO_OP: wdata_o = lo_cur;
               EXE_MOVZ_OP, EXE_MOVN_OP: wdata_o = reg1_i;
               default:     wdata_o = '0;
            endcase
         end
         EXE_RES_ARITH: begin
            case (aluop_i)
               EXE_ADD_OP, EXE_ADDU_OP, EXE_ADDI_OP, EXE_ADDIU_OP: wdata_o = sum;
               EXE_SUB_OP, EXE_SUBU_OP: wdata_o = diff;
               EXE_SLT_OP:  wdata_o = {31'd0, $signed(reg1_i) < $signed(reg2_i)};
               EXE_SLTU_OP: wdata_o = {31'd0, reg1_i < reg2_i};
               default:     wdata_o = '0;
            endcase
         end
         EXE_RES_MUL:         wdata_o = prod_s[31:0];
         EXE_RES_JUMP_BRANCH: wdata_o = link_address_i;
         default:             wdata_o = '0;
      endcase
   end

   always_comb begin
      whilo_o = 1'b0;
      hi_o    = '0;
      lo_o    = '0;
      case (aluop_i)
         EXE_MULT_OP:  begin whilo_o = 1'b1; {hi_o, lo_o} = prod_s; end
         EXE_MULTU_OP: begin whilo_o = 1'b1; {hi_o, lo_o} = prod_u; end
         EXE_MTHI_OP:  begin whilo_o = 1'b1; hi_o = reg1_i; lo_o = lo_cur; end
         EXE_MTLO_OP:  begin whilo_o = 1'b1; hi_o = hi_cur; lo_o = reg1_i; end
         EXE_DIV_OP, EXE_DIVU_OP: begin
            whilo_o = div_ready;
            {hi_o, lo_o} = div_result;
         end
         default: ;
      endcase
   end

   always_comb begin
      excepttype_o             = excepttype_i;
      excepttype_o[EXC_OV_BIT] = excepttype_i[EXC_OV_BIT] | ov;
      excepttype_o[EXC_RI_BIT] = excepttype_i[EXC_RI_BIT] | div_rsvd;
   end

   assign wd_o                   = wd_i;
   assign wreg_o                 = wreg_i && !ov;
   assign mem_addr_o             = reg1_i + {{16{inst_i[15]}}, inst_i[15:0]};
   assign reg2_o                 = reg2_i;
   assign aluop_o                = aluop_i;
   assign current_inst_address_o = current_inst_address_i;
   assign is_in_delayslot_o      = is_in_delayslot_i;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases, randomized ops against an
// arithmetic reference model, and divider timing (EX_DIV_EN build).
module tb_ex_stage;
   import ex_stage_pkg::*;

   localparam longint S32_MAX = 64'sd2147483647;
   localparam longint S32_MIN = -64'sd2147483648;

   logic        clk = 1'b0;
   logic        rst, flush, stall_i;
   logic [7:0]  aluop_i;
   logic [2:0]  alusel_i;
   logic [31:0] reg1_i, reg2_i, link_address_i, inst_i, current_inst_address_i, excepttype_i;
   logic [4:0]  wd_i;
   logic        wreg_i, is_in_delayslot_i;
   logic [31:0] hi_i, lo_i, mem_hi_i, mem_lo_i, wb_hi_i, wb_lo_i;
   logic        mem_whilo_i, wb_whilo_i;
   logic [4:0]  wd_o;
   logic        wreg_o, whilo_o, is_in_delayslot_o, stallreq_o;
   logic [31:0] wdata_o, hi_o, lo_o, mem_addr_o, reg2_o, excepttype_o, current_inst_address_o;
   logic [7:0]  aluop_o;

   int checks = 0;
   int errors = 0;

   ex_stage dut (
      .clk(clk), .rst(rst), .flush(flush), .stall_i(stall_i),
      .aluop_i(aluop_i), .alusel_i(alusel_i), .reg1_i(reg1_i), .reg2_i(reg2_i),
      .wd_i(wd_i), .wreg_i(wreg_i), .link_address_i(link_address_i), .inst_i(inst_i),
      .current_inst_address_i(current_inst_address_i), .excepttype_i(excepttype_i),
      .is_in_delayslot_i(is_in_delayslot_i), .hi_i(hi_i), .lo_i(lo_i),
      .mem_whilo_i(mem_whilo_i), .mem_hi_i(mem_hi_i), .mem_lo_i(mem_lo_i),
      .wb_whilo_i(wb_whilo_i), .wb_hi_i(wb_hi_i), .wb_lo_i(wb_lo_i),
      .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o), .whilo_o(whilo_o),
      .hi_o(hi_o), .lo_o(lo_o), .mem_addr_o(mem_addr_o), .reg2_o(reg2_o),
      .aluop_o(aluop_o), .excepttype_o(excepttype_o),
      .current_inst_address_o(current_inst_address_o),
      .is_in_delayslot_o(is_in_delayslot_o), .stallreq_o(stallreq_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] wdata;
      logic        wreg;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [31:0] exc;
   } exp_t;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Expected outputs from the instruction semantics, using 64-bit arithmetic
   function automatic exp_t model();
      exp_t e;
      longint a  = longint'($signed(reg1_i));
      longint b  = longint'($signed(reg2_i));
      longint unsigned ua = longint'({32'd0, reg1_i});
      longint unsigned ub = longint'({32'd0, reg2_i});
      longint s;
      longint unsigned u;
      logic [31:0] hs = mem_whilo_i ? mem_hi_i : (wb_whilo_i ? wb_hi_i : hi_i);
      logic [31:0] ls = mem_whilo_i ? mem_lo_i : (wb_whilo_i ? wb_lo_i : lo_i);
      e = '0;
      e.wreg = wreg_i;
      e.exc  = excepttype_i;
      case (aluop_i)
         EXE_AND_OP: e.wdata = reg1_i & reg2_i;
         EXE_OR_OP:  e.wdata = reg1_i | reg2_i;
         EXE_XOR_OP: e.wdata = reg1_i ^ reg2_i;
         EXE_NOR_OP: e.wdata = ~(reg1_i | reg2_i);
         EXE_SLL_OP: begin u = ub * (64'd1 << reg1_i[4:0]); e.wdata = u[31:0]; end
         EXE_SRL_OP: begin u = ub / (64'd1 << reg1_i[4:0]); e.wdata = u[31:0]; end
         EXE_SRA_OP: begin s = b >>> reg1_i[4:0]; e.wdata = s[31:0]; end
         EXE_SLT_OP:  e.wdata = (a < b) ? 32'd1 : 32'd0;
         EXE_SLTU_OP: e.wdata = (ua < ub) ? 32'd1 : 32'd0;
         EXE_ADD_OP, EXE_ADDI_OP, EXE_SUB_OP: begin
            s = (aluop_i == EXE_SUB_OP) ? a - b : a + b;
            e.wdata = s[31:0];
            if (s > S32_MAX || s < S32_MIN) begin
               e.wreg    = 1'b0;
               e.exc[12] = 1'b1;
            end
         end
         EXE_ADDU_OP, EXE_ADDIU_OP: begin s = a + b; e.wdata = s[31:0]; end
         EXE_SUBU_OP: begin s = a - b; e.wdata = s[31:0]; end
         EXE_MULT_OP:  begin s = a * b; e.whilo = 1'b1; e.hi = s[63:32]; e.lo = s[31:0]; end
         EXE_MULTU_OP: begin u = ua * ub; e.whilo = 1'b1; e.hi = u[63:32]; e.lo = u[31:0]; end
         EXE_MUL_OP:   begin s = a * b; e.wdata = s[31:0]; end
         EXE_MFHI_OP:  e.wdata = hs;
         EXE_MFLO_OP:  e.wdata = ls;
         EXE_MOVZ_OP, EXE_MOVN_OP: e.wdata = reg1_i;
         EXE_MTHI_OP:  begin e.whilo = 1'b1; e.hi = reg1_i; e.lo = ls; end
         EXE_MTLO_OP:  begin e.whilo = 1'b1; e.hi = hs; e.lo = reg1_i; end
         EXE_JAL_OP:   e.wdata = link_address_i;
`ifndef EX_DIV_EN
         EXE_DIV_OP, EXE_DIVU_OP: e.exc[9] = 1'b1;
`endif
         default: e.wdata = '0;
      endcase
      return e;
   endfunction

   task automatic check_comb(input string tag);
      exp_t e;
      longint ea;
      e  = model();
      ea = longint'($signed(reg1_i)) + longint'($signed(inst_i[15:0]));
      check({tag, ".wdata"}, wdata_o, e.wdata);
      check({tag, ".wreg"}, wreg_o, e.wreg);
      check({tag, ".whilo"}, whilo_o, e.whilo);
      check({tag, ".exc"}, excepttype_o, e.exc);
      if (e.whilo) begin
         check({tag, ".hi"}, hi_o, e.hi);
         check({tag, ".lo"}, lo_o, e.lo);
      end
      check({tag, ".mem_addr"}, mem_addr_o, ea[31:0]);
      check({tag, ".pass"}, {wd_o, reg2_o, aluop_o, current_inst_address_o, is_in_delayslot_o},
            {wd_i, reg2_i, aluop_i, current_inst_address_i, is_in_delayslot_i});
      check({tag, ".stallreq"}, stallreq_o, 1'b0);
   endtask

   task automatic set_op(input logic [7:0] op, input logic [2:0] sel,
                         input logic [31:0] r1, input logic [31:0] r2);
      aluop_i = op; alusel_i = sel; reg1_i = r1; reg2_i = r2;
   endtask

   task automatic pick_op(input int k);
      case (k)
         0:  set_op(EXE_AND_OP,   EXE_RES_LOGIC, reg1_i, reg2_i);
         1:  set_op(EXE_OR_OP,    EXE_RES_LOGIC, reg1_i, reg2_i);
         2:  set_op(EXE_XOR_OP,   EXE_RES_LOGIC, reg1_i, reg2_i);
         3:  set_op(EXE_NOR_OP,   EXE_RES_LOGIC, reg1_i, reg2_i);
         4:  set_op(EXE_SLL_OP,   EXE_RES_SHIFT, reg1_i, reg2_i);
         5:  set_op(EXE_SRL_OP,   EXE_RES_SHIFT, reg1_i, reg2_i);
         6:  set_op(EXE_SRA_OP,   EXE_RES_SHIFT, reg1_i, reg2_i);
         7:  set_op(EXE_SLT_OP,   EXE_RES_ARITH, reg1_i, reg2_i);
         8:  set_op(EXE_SLTU_OP,  EXE_RES_ARITH, reg1_i, reg2_i);
         9:  set_op(EXE_ADD_OP,   EXE_RES_ARITH, reg1_i, reg2_i);
         10: set_op(EXE_ADDU_OP,  EXE_RES_ARITH, reg1_i, reg2_i);
         11: set_op(EXE_SUB_OP,   EXE_RES_ARITH, reg1_i, reg2_i);
         12: set_op(EXE_SUBU_OP,  EXE_RES_ARITH, reg1_i, reg2_i);
         13: set_op(EXE_ADDI_OP,  EXE_RES_ARITH, reg1_i, reg2_i);
         14: set_op(EXE_MULT_OP,  EXE_RES_NOP,   reg1_i, reg2_i);
         15: set_op(EXE_MULTU_OP, EXE_RES_NOP,   reg1_i, reg2_i);
         16: set_op(EXE_MUL_OP,   EXE_RES_MUL,   reg1_i, reg2_i);
         17: set_op(EXE_MFHI_OP,  EXE_RES_MOVE,  reg1_i, reg2_i);
         18: set_op(EXE_MFLO_OP,  EXE_RES_MOVE,  reg1_i, reg2_i);
         19: set_op(EXE_MTHI_OP,  EXE_RES_NOP,   reg1_i, reg2_i);
         20: set_op(EXE_MTLO_OP,  EXE_RES_NOP,   reg1_i, reg2_i);
         21: set_op(EXE_MOVN_OP,  EXE_RES_MOVE,  reg1_i, reg2_i);
         22: set_op(EXE_JAL_OP,   EXE_RES_JUMP_BRANCH, reg1_i, reg2_i);
         default: set_op(EXE_LW_OP, EXE_RES_LOAD_STORE, reg1_i, reg2_i);
      endcase
   endtask

   task automatic randomize_inputs();
      reg1_i = $urandom;
      reg2_i = $urandom;
      if ($urandom_range(0, 3) == 0) reg1_i = ($urandom_range(0, 1) == 0) ? 32'h7FFF_FFFF : 32'h8000_0000;
      if ($urandom_range(0, 3) == 0) reg2_i = $urandom_range(0, 2);
      pick_op($urandom_range(0, 23));
      wd_i = 5'($urandom); wreg_i = 1'($urandom);
      inst_i = $urandom; link_address_i = $urandom;
      current_inst_address_i = $urandom; is_in_delayslot_i = 1'($urandom);
      excepttype_i = $urandom & 32'hFFFF_EDFF;
      hi_i = $urandom; lo_i = $urandom;
      mem_whilo_i = 1'($urandom); mem_hi_i = $urandom; mem_lo_i = $urandom;
      wb_whilo_i = 1'($urandom); wb_hi_i = $urandom; wb_lo_i = $urandom;
   endtask

   // Called just after a rising edge; returns just after the edge where the FSM has left END
   task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                          input logic [31:0] b, input int hold);
      longint la, lb, q, r;
      int n, exp_n;
      la = sgn ? longint'($signed(a)) : longint'({32'd0, a});
      lb = sgn ? longint'($signed(b)) : longint'({32'd0, b});
      if (lb == 0) begin q = 0; r = 0; exp_n = 2; end
      else begin q = la / lb; r = la % lb; exp_n = 33; end
      excepttype_i = 32'd0;
      set_op(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b);
      stall_i = 1'b0;
`ifdef EX_DIV_EN
      n = 0;
      while (n < 100) begin
         @(negedge clk);
         if (!stallreq_o) break;
         n++;
         @(posedge clk);
      end
      check({tag, ".stall_cycles"}, n, exp_n);
      check({tag, ".whilo"}, whilo_o, 1'b1);
      check({tag, ".hi"}, hi_o, r[31:0]);
      check({tag, ".lo"}, lo_o, q[31:0]);
      stall_i = (hold > 0);
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         @(negedge clk);
         check({tag, ".held"}, {stallreq_o, whilo_o, hi_o, lo_o}, {1'b0, 1'b1, r[31:0], q[31:0]});
      end
      stall_i = 1'b0;
      @(posedge clk); #1;
`else
      @(negedge clk);
      check({tag, ".nodiv"}, {stallreq_o, whilo_o, excepttype_o[9]}, {1'b0, 1'b0, 1'b1});
      @(posedge clk); #1;
      check({tag, ".nodiv2"}, {stallreq_o, whilo_o}, {1'b0, exp_n == 0});
`endif
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; stall_i = 1'b0;
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
      wd_i = 5'd3; wreg_i = 1'b1; link_address_i = 32'h100; inst_i = 32'h0000_0004;
      current_inst_address_i = 32'h400; excepttype_i = 32'd0; is_in_delayslot_i = 1'b0;
      hi_i = 32'hC; lo_i = 32'hC0; mem_whilo_i = 1'b0; mem_hi_i = 32'hA; mem_lo_i = 32'hA0;
      wb_whilo_i = 1'b0; wb_hi_i = 32'hB; wb_lo_i = 32'hB0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset", {stallreq_o, whilo_o, wdata_o}, 34'd0);

      @(posedge clk); #1 set_op(EXE_ADD_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
      @(negedge clk);
      check("add_ovf.wreg", wreg_o, 1'b0);
      check("add_ovf.exc12", excepttype_o[12], 1'b1);
      check_comb("add_ovf");
      @(posedge clk); #1 set_op(EXE_ADDU_OP, EXE_RES_ARITH, 32'h7FFF_FFFF, 32'd1);
      @(negedge clk);
      check("addu.wdata", wdata_o, 32'h8000_0000);
      check("addu.wreg", wreg_o, 1'b1);
      @(posedge clk); #1 set_op(EXE_SUB_OP, EXE_RES_ARITH, 32'd0, 32'h8000_0000);
      @(negedge clk);
      check("sub_ovf.exc12", excepttype_o[12], 1'b1);
      @(posedge clk); #1 set_op(EXE_MFHI_OP, EXE_RES_MOVE, 32'd0, 32'd0);
      mem_whilo_i = 1'b1; wb_whilo_i = 1'b1;
      @(negedge clk);
      check("mfhi_mem", wdata_o, 32'hA);
      @(posedge clk); #1 mem_whilo_i = 1'b0;
      @(negedge clk);
      check("mfhi_wb", wdata_o, 32'hB);
      @(posedge clk); #1 wb_whilo_i = 1'b0; set_op(EXE_MFLO_OP, EXE_RES_MOVE, 32'd0, 32'd0);
      @(negedge clk);
      check("mflo_arch", wdata_o, 32'hC0);
      @(posedge clk); #1 set_op(EXE_JAL_OP, EXE_RES_JUMP_BRANCH, 32'd5, 32'd6);
      @(negedge clk);
      check("jal_link", wdata_o, 32'h100);

      for (int i = 0; i < 300; i++) begin
         @(posedge clk); #1 randomize_inputs();
         @(negedge clk);
         check_comb("rnd");
      end

      @(posedge clk); #1;
      set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
      run_div("div_m7_2", 1'b1, 32'hFFFF_FFF9, 32'd2, 0);
      run_div("divu_by0", 1'b0, 32'd5, 32'd0, 0);
      run_div("div_hold", 1'b1, 32'd100, 32'hFFFF_FFF9, 3);
      for (int i = 0; i < 3; i++) begin
         run_div("div_rnd", 1'($urandom), $urandom, $urandom | 32'd1, 0);
      end

`ifdef EX_DIV_EN
      set_op(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd7);
      repeat (10) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush.now", {stallreq_o, whilo_o}, 2'b00);
      @(posedge clk); #1 flush = 1'b0; set_op(EXE_NOP_OP, EXE_RES_NOP, 32'd0, 32'd0);
      @(negedge clk);
      check("flush.after", {stallreq_o, whilo_o}, 2'b00);
      @(posedge clk); #1;
      run_div("div_after_flush", 1'b0, 32'd1000, 32'd7, 0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ex_stage.md
# ex_stage

Execute stage of the five-stage MIPS32 pipeline, sitting directly downstream of the ID/EX pipeline register and feeding the EX/MEM register. It computes ALU, shift, move, multiply and link results, and checks for arithmetic overflow. It resolves HI/LO forwarding and computes load/store effective addresses. An iterative signed/unsigned divider runs here as a multi-cycle FSM, and the stage requests a pipeline stall while the divider is busy.

## Interface
Parameters:
- DIV_CYCLES, 32, number of quotient-bit iterations; fixed by the 32-bit datapath, not to be overridden.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  exception flush; aborts any divide in progress.
- stall_i  in  1  EX frozen by a downstream stall (stall[3]).
- aluop_i / alusel_i  in  8 / 3  operation and result select from ID/EX.
- reg1_i, reg2_i  in  32 each  source operands.
- wd_i / wreg_i  in  5 / 1  destination register and write enable.
- link_address_i, inst_i, current_inst_address_i, excepttype_i  in  32 each  pass-through and sideband inputs.
- is_in_delayslot_i  in  1  delay-slot flag.
- hi_i, lo_i  in  32 each  architectural HI/LO.
- mem_whilo_i, mem_hi_i, mem_lo_i  in  1/32/32  HI/LO forward from MEM.
- wb_whilo_i, wb_hi_i, wb_lo_i  in  1/32/32  HI/LO forward from WB.
- wd_o, wreg_o, wdata_o  out  5/1/32  GPR write-back request.
- whilo_o, hi_o, lo_o  out  1/32/32  HI/LO write request.
- mem_addr_o, reg2_o, aluop_o  out  32/32/8  to the memory stage.
- excepttype_o, current_inst_address_o, is_in_delayslot_o  out  32/32/1  to exception logic.
- stallreq_o  out  1  stall request to pipeline control.

## Operation
- Datapath outputs are combinational from the inputs and divider state. The EX/MEM register registers them.
- Logic, shift and arithmetic ops follow the defines-header opcodes.
- SLT/SLTU use signed and unsigned compares respectively.
- MULT/MULTU produce a 64-bit product in a single cycle: HI = [63:32], LO = [31:0].
- HI/LO source priority: MEM forward > WB forward > hi_i/lo_i.
- ADD/ADDI/SUB with signed overflow:
  - wreg_o = 0.
  - excepttype_o bit 12 = 1.
  - All other excepttype bits pass through unchanged.
- ADDU/ADDIU/SUBU never trap.
- mem_addr_o = reg1_i + sign-extended inst_i[15:0].
- reg2_o = reg2_i. aluop_o = aluop_i.
- For alusel = jump/branch, wdata_o = link_address_i.
- Divider FSM (sub-module div_unit), states IDLE, BY_ZERO, ON, END:
  - IDLE → BY_ZERO when a DIV/DIVU is present and reg2_i = 0.
  - IDLE → ON when a DIV/DIVU is present and the divisor is nonzero. For DIV, operands are converted to magnitudes.
  - ON: restoring division, one quotient bit per cycle. After DIV_CYCLES iterations → END.
  - BY_ZERO → END with quotient = 0, remainder = 0.
  - END: result is valid. For DIV, quotient sign = sign(reg1) XOR sign(reg2), and remainder sign = sign(reg1).
  - END → IDLE when stall_i = 0. END holds while stall_i = 1.
  - flush or rst in any state → IDLE; the counter clears.
- Divide result: LO = quotient, HI = remainder, whilo_o = 1 only in END.
- stallreq_o = 1 while a DIV/DIVU is present and the FSM is not in END. It is 0 otherwise.

## Timing
- Reset state: FSM IDLE, counter 0, result register 0. stallreq_o = 0 whenever no divide is present.
- Non-divide ops: zero added latency, stallreq_o = 0.
- DIV/DIVU with nonzero divisor, entering EX in cycle 0:
  - stallreq_o = 1 in cycles 0–32.
  - END in cycle 33, with stallreq_o = 0 and the result on hi_o/lo_o.
- Divide by zero: stallreq_o = 1 in cycles 0–1; END in cycle 2.
- Back-to-back divides: END → IDLE takes one cycle, and the second divide starts from IDLE in the next cycle.
- A flush mid-divide drops stallreq_o combinationally in the same cycle. No HI/LO write occurs.

## Configuration
- EX_DIV_EN defined: div_unit is instantiated and behaves as above.
- EX_DIV_EN undefined: div_unit is omitted. DIV/DIVU then give whilo_o = 0 and stallreq_o = 0, and set excepttype_o bit 9 (reserved instruction).

## Structure
- Opcodes, alusel codes, DIV FSM state encodings and excepttype bit positions go in the shared defines header.
- The single sub-module div_unit has ports:
  - clk, rst, signed_div, opdata1, opdata2, start, annul, release.
  - result[63:0], ready.

## Test plan
- ADD with reg1 = 0x7FFFFFFF, reg2 = 1 → wreg_o = 0, excepttype_o bit 12 = 1. ADDU with the same operands → wdata_o = 0x80000000.
- DIV with reg1 = −7, reg2 = 2 → stallreq_o high for 33 cycles, then LO = 0xFFFFFFFD (−3), HI = 0xFFFFFFFF (−1), whilo_o = 1.
- DIVU with reg1 = 5, reg2 = 0 → stall for 2 cycles, then HI = LO = 0.
- MFHI with mem_whilo_i = 1 (mem_hi_i = 0xA), wb_whilo_i = 1 (wb_hi_i = 0xB), hi_i = 0xC → wdata_o = 0xA.
- DIV flushed in cycle 10 → stallreq_o = 0 at once, FSM in IDLE next cycle, no whilo_o. Also: stall_i held for 3 cycles in END → result held, then IDLE.
